// File: rtl/rom_operand_fetch.sv
// rom_operand_fetch: walks the operand ROM, pairs consecutive words into (a, b)
// and hands them to the adder stage through a 2-entry valid/ready FIFO.
module rom_operand_fetch #(
    parameter int BW    = 8,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    output logic          rom_en,
    output logic [AW-1:0] rom_addr,
    input  logic [BW-1:0] rom_rdata,
    output logic          op_valid,
    input  logic          op_ready,
    output logic [BW-1:0] op_a,
    output logic [BW-1:0] op_b,
    output logic [AW-2:0] op_idx,
    output logic          busy,
    output logic          done
);
    localparam int NPAIRS = DEPTH / 2;
    localparam int KW = AW - 1;

    typedef enum logic [2:0] {IDLE, REQ_A, REQ_B, LAT_B, WAIT, DRAIN} state_t;

    state_t               state_q, state_d;
    logic [KW-1:0]        k_q, k_d;
    logic [BW-1:0]        a_q;
    logic [AW-1:0]        addr_q;
    logic [1:0][BW-1:0]   fa_q, fb_q;
    logic [1:0][KW-1:0]   fi_q;
    logic                 wp_q, rp_q;
    logic [1:0]           cnt_q, cnt_d;
    logic                 push, pop, last;

    assign push  = state_q == LAT_B;
    assign pop   = op_valid && op_ready;
    assign last  = k_q == KW'(NPAIRS - 1);
    // Credit check looks at the occupancy after this cycle's push/pop so a
    // freed slot restarts the fetch without a bubble.
    assign cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
        end
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        case (state_q)
            IDLE: begin
                k_d = '0;
                if (start) state_d = REQ_A;
            end
            REQ_A: state_d = REQ_B;
            REQ_B: state_d = LAT_B;
            LAT_B: begin
                state_d = last ? DRAIN : (cnt_d < 2'd2 ? REQ_A : WAIT);
                if (!last) k_d = k_q + KW'(1);
            end
            WAIT:  if (cnt_d < 2'd2) state_d = REQ_A;
            DRAIN: if (cnt_q == 2'd0) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rom_en   = state_q == REQ_A || state_q == REQ_B;
        rom_addr = state_q == REQ_A ? {k_q, 1'b0} : state_q == REQ_B ? {k_q, 1'b1} : addr_q;
        busy     = state_q != IDLE;
        done     = state_q == DRAIN && cnt_q == 2'd0;
        op_valid = cnt_q != 2'd0;
        op_a     = fa_q[rp_q];
        op_b     = fb_q[rp_q];
        op_idx   = fi_q[rp_q];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            addr_q <= '0;
            fa_q   <= '0;
            fb_q   <= '0;
            fi_q   <= '0;
            wp_q   <= 1'b0;
            rp_q   <= 1'b0;
            cnt_q  <= '0;
        end else begin
            if (state_q == REQ_B) a_q <= rom_rdata;
            if (push) begin
                fa_q[wp_q] <= a_q;
                fb_q[wp_q] <= rom_rdata;
                fi_q[wp_q] <= k_q;
                wp_q       <= ~wp_q;
            end
            if (pop) rp_q <= ~rp_q;
            cnt_q  <= cnt_d;
            addr_q <= rom_addr;
        end
    end
endmodule

// File: tb/tb_rom_operand_fetch.sv
// tb_rom_operand_fetch: directed checks of reset, pairing, latency, backpressure, starts and done
module tb_rom_operand_fetch;
  logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0, op_ready = 1'b0;
  logic       rom_en, op_valid, busy, done;
  logic [3:0] rom_addr;
  logic [7:0] rom_rdata, op_a, op_b;
  logic [2:0] op_idx;
  logic [7:0] rom [16];
  int total = 0, bad = 0;
  rom_operand_fetch #(.BW(8), .DEPTH(16), .AW(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .rom_en(rom_en), .rom_addr(rom_addr),
    .rom_rdata(rom_rdata), .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a),
    .op_b(op_b), .op_idx(op_idx), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (rom_en) rom_rdata <= rom[rom_addr];
  task automatic load_rom(input int mul);
    for (int i = 0; i < 16; i++) rom[i] = 8'(i * mul + 1);
  endtask
  task automatic start_pass();
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    op_ready = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({rom_en, rom_addr, op_valid, op_a, op_b, op_idx, busy, done} !== 27'd0) begin
      bad++;
      $display("FAIL reset_outputs got=%h want=0", {rom_en, rom_addr, op_valid, op_a, op_b, op_idx, busy, done});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask
  task automatic test_full_pass();
    bit ev;
    int k;
    op_ready = 1'b1;
    load_rom(1);
    start_pass();
    for (int c = 1; c <= 27; c++) begin
      @(negedge clk);
      ev = c >= 4 && c <= 25 && (c - 4) % 3 == 0;
      total++;
      if ({op_valid, done, busy} !== {ev, c == 26, c <= 26}) begin
        bad++;
        $display("FAIL full_flags c=%0d got v/d/b=%b%b%b want=%b%b%b", c, op_valid, done, busy, ev, c == 26, c <= 26);
      end
      if (ev) begin
        k = (c - 4) / 3;
        total++;
        if ({op_idx, op_a, op_b} !== {3'(k), 8'(2 * k + 1), 8'(2 * k + 2)}) begin
          bad++;
          $display("FAIL full_pair c=%0d got idx=%0d a=%0d b=%0d want idx=%0d a=%0d b=%0d", c, op_idx, op_a, op_b, k, 2 * k + 1, 2 * k + 2);
        end
      end
      if (c == 1 || c == 2) begin
        total++;
        if ({rom_en, rom_addr} !== {1'b1, 4'(c - 1)}) begin
          bad++;
          $display("FAIL full_req c=%0d got en=%b addr=%0d want en=1 addr=%0d", c, rom_en, rom_addr, c - 1);
        end
      end
    end
  endtask
  task automatic test_backpressure();
    int nk = 1;
    bit got = 0;
    op_ready = 1'b0;
    load_rom(1);
    start_pass();
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      total++;
      if (rom_en !== (c == 1 || c == 2 || c == 4 || c == 5)) begin
        bad++;
        $display("FAIL bp_rom_en c=%0d got=%b", c, rom_en);
      end
      if (c >= 4) begin
        total++;
        if ({op_valid, op_idx, op_a, op_b} !== {1'b1, 3'd0, 8'd1, 8'd2}) begin
          bad++;
          $display("FAIL bp_hold c=%0d got v=%b idx=%0d a=%0d b=%0d want v=1 idx=0 a=1 b=2", c, op_valid, op_idx, op_a, op_b);
        end
      end
      if (c == 20) op_ready = 1'b1;
    end
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      if (i == 0) begin
        total++;
        if ({rom_en, rom_addr} !== {1'b1, 4'd4}) begin
          bad++;
          $display("FAIL bp_resume got en=%b addr=%0d want en=1 addr=4", rom_en, rom_addr);
        end
      end
      if (op_valid) begin
        total++;
        if ({op_idx, op_a, op_b} !== {3'(nk), 8'(2 * nk + 1), 8'(2 * nk + 2)}) begin
          bad++;
          $display("FAIL bp_pair got idx=%0d a=%0d b=%0d want idx=%0d a=%0d b=%0d", op_idx, op_a, op_b, nk, 2 * nk + 1, 2 * nk + 2);
        end
        nk++;
      end
      if (done) got = 1;
    end
    total++;
    if (!(got && nk == 8)) begin
      bad++;
      $display("FAIL bp_end got pairs=%0d done=%b want pairs=8 done=1", nk, got);
    end
  endtask
  task automatic test_push_pop();
    bit got = 0;
    op_ready = 1'b0;
    load_rom(1);
    start_pass();
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 6) begin
        op_ready = 1'b1;
        total++;
        if ({op_valid, op_idx} !== {1'b1, 3'd0}) begin
          bad++;
          $display("FAIL pp_pre got v=%b idx=%0d want v=1 idx=0", op_valid, op_idx);
        end
      end
      if (c == 7) begin
        total++;
        if ({op_valid, op_idx, op_a, op_b, rom_en, rom_addr} !== {1'b1, 3'd1, 8'd3, 8'd4, 1'b1, 4'd4}) begin
          bad++;
          $display("FAIL pp_next got v=%b idx=%0d a=%0d b=%0d en=%b addr=%0d want 1 1 3 4 1 4", op_valid, op_idx, op_a, op_b, rom_en, rom_addr);
        end
      end
      if (c == 8) begin
        total++;
        if (op_valid !== 1'b0) begin
          bad++;
          $display("FAIL pp_empty got v=%b want 0", op_valid);
        end
      end
    end
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      if (done) got = 1;
    end
    total++;
    if (!got) begin
      bad++;
      $display("FAIL pp_done got=0 want=1");
    end
  endtask
  task automatic test_start_ignored();
    int nd = 0;
    bit got = 0;
    op_ready = 1'b1;
    load_rom(1);
    start_pass();
    for (int c = 1; c <= 27; c++) begin
      @(negedge clk);
      start = (c == 5 || c == 12 || c == 27);
      if (done) nd++;
      if (c == 26) begin
        total++;
        if (done !== 1'b1) begin
          bad++;
          $display("FAIL ign_done26 got=%b want=1", done);
        end
      end
      if (c == 27) begin
        total++;
        if (busy !== 1'b0) begin
          bad++;
          $display("FAIL ign_idle27 got busy=%b want=0", busy);
        end
      end
    end
    total++;
    if (nd != 1) begin
      bad++;
      $display("FAIL ign_done_count got=%0d want=1", nd);
    end
    @(negedge clk);
    start = 1'b0;
    total++;
    if ({rom_en, rom_addr, busy} !== {1'b1, 4'd0, 1'b1}) begin
      bad++;
      $display("FAIL b2b_restart got en=%b addr=%0d busy=%b want 1 0 1", rom_en, rom_addr, busy);
    end
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      if (done) got = 1;
    end
    total++;
    if (!got) begin
      bad++;
      $display("FAIL b2b_done got=0 want=1");
    end
  endtask
  task automatic test_random();
    int nk;
    bit hold, got;
    logic [18:0] held;
    for (int p = 0; p < 3; p++) begin
      load_rom(3 + 2 * p);
      op_ready = 1'b0;
      nk = 0;
      hold = 0;
      got = 0;
      start_pass();
      for (int i = 0; i < 300 && !got; i++) begin
        @(negedge clk);
        op_ready = 1'($urandom_range(0, 1));
        if (hold) begin
          total++;
          if ({op_valid, op_idx, op_a, op_b} !== {1'b1, held}) begin
            bad++;
            $display("FAIL rnd_stable p=%0d got v=%b %h want v=1 %h", p, op_valid, {op_idx, op_a, op_b}, held);
          end
        end
        hold = 0;
        if (op_valid && op_ready) begin
          total++;
          if ({op_idx, op_a, op_b} !== {3'(nk), rom[2 * nk], rom[2 * nk + 1]}) begin
            bad++;
            $display("FAIL rnd_pair p=%0d got idx=%0d a=%0d b=%0d want idx=%0d a=%0d b=%0d", p, op_idx, op_a, op_b, nk, rom[2 * nk], rom[2 * nk + 1]);
          end
          nk++;
        end else if (op_valid) begin
          hold = 1;
          held = {op_idx, op_a, op_b};
        end
        if (done) got = 1;
      end
      total++;
      if (!(got && nk == 8)) begin
        bad++;
        $display("FAIL rnd_end p=%0d got pairs=%0d done=%b want 8 1", p, nk, got);
      end
    end
    op_ready = 1'b0;
  endtask
  task automatic test_reset_mid_pass();
    op_ready = 1'b1;
    load_rom(1);
    start_pass();
    for (int c = 1; c <= 10; c++) @(negedge clk);
    total++;
    if ({op_valid, rom_en, busy} !== 3'b111) begin
      bad++;
      $display("FAIL mid_pre got v/en/b=%b want 111", {op_valid, rom_en, busy});
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({op_valid, rom_en, busy, done, op_idx} !== 7'd0) begin
      bad++;
      $display("FAIL mid_reset got v/en/b/d/idx=%b want 0", {op_valid, rom_en, busy, done, op_idx});
    end
    @(negedge clk) rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      total++;
      if ({op_valid, rom_en, busy, done} !== 4'd0) begin
        bad++;
        $display("FAIL mid_idle c=%0d got v/en/b/d=%b want 0000", c, {op_valid, rom_en, busy, done});
      end
    end
  endtask
  initial begin
    test_reset();
    test_full_pass();
    test_backpressure();
    test_push_pop();
    test_start_ignored();
    test_random();
    test_reset_mid_pass();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
